// File: rtl/card_dealer.sv
// card_dealer: deals cards one at a time from a tracked 52-card deck.
// A card is never repeated until the deck is restocked. Each deal raises a
// one-cycle card_valid strobe. The start position of the search for a free
// card comes from a free-running LFSR.

module card_dealer #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       draw,
  input  logic       new_deck,
  output logic [3:0] card,
  output logic [1:0] suit,
  output logic [5:0] card_index,
  output logic       card_valid,
  output logic       busy,
  output logic       deck_empty,
  output logic [5:0] cards_left
);

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DEAL
  } state_t;

  state_t      state;
  logic [15:0] lfsr;
  logic        draw_q;
  logic        rise;
  logic [51:0] dealt;
  logic [5:0]  probe;
  logic [5:0]  start_index;
  logic [5:0]  next_probe;
  logic        probe_free;
  logic [1:0]  probe_suit;
  logic [3:0]  rank_base;
  logic [3:0]  probe_rank;

  // Fibonacci LFSR (taps 16,14,13,11) advancing every cycle outside reset
  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  // Previous draw level; starts high so a key held through reset never deals
  always_ff @(posedge clock) begin
    if (reset) begin
      draw_q <= 1'b1;
    end else begin
      draw_q <= draw;
    end
  end

  assign rise        = draw & ~draw_q;
  assign start_index = (lfsr[5:0] < 6'd52) ? lfsr[5:0] : lfsr[5:0] - 6'd12;
  assign next_probe  = (probe == 6'd51) ? 6'd0 : probe + 6'd1;
  assign probe_free  = ~dealt[probe];
  assign busy        = (state != IDLE);
  assign deck_empty  = (cards_left == 6'd0);

  // Suit from a comparator chain; rank_base holds the suit's first index mod 16
  always_comb begin
    probe_suit = 2'd0;
    rank_base  = 4'd0;
    if (probe >= 6'd39) begin
      probe_suit = 2'd3;
      rank_base  = 4'd7;
    end else if (probe >= 6'd26) begin
      probe_suit = 2'd2;
      rank_base  = 4'd10;
    end else if (probe >= 6'd13) begin
      probe_suit = 2'd1;
      rank_base  = 4'd13;
    end
  end

  // The true rank is 1..13, so wrapping 4-bit arithmetic on the low bits is exact
  assign probe_rank = probe[3:0] - rank_base + 4'd1;

  // Deal state machine: waits for a draw edge, probes for a free card, presents it
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      dealt      <= '0;
      cards_left <= 6'd52;
      card       <= 4'd0;
      suit       <= 2'd0;
      card_index <= 6'd0;
      card_valid <= 1'b0;
      probe      <= 6'd0;
    end else begin
      card_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (new_deck) begin
            dealt      <= '0;
            cards_left <= 6'd52;
            card       <= 4'd0;
          end else if (rise && !deck_empty) begin
            probe <= start_index;
            state <= SEARCH;
          end
        end
        SEARCH: begin
          if (new_deck) begin
            dealt      <= '0;
            cards_left <= 6'd52;
            card       <= 4'd0;
            state      <= IDLE;
          end else if (probe_free) begin
            card         <= probe_rank;
            suit         <= probe_suit;
            card_index   <= probe;
            dealt[probe] <= 1'b1;
            cards_left   <= cards_left - 6'd1;
            state        <= DEAL;
          end else begin
            probe <= next_probe;
          end
        end
        DEAL: begin
          card_valid <= 1'b1;
          state      <= IDLE;
          if (new_deck) begin
            dealt      <= '0;
            cards_left <= 6'd52;
            card       <= 4'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
